// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcode/funct encodings, fetch FSM states.
// Also holds the fetch buffer entry layout and the word-alignment helper.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [INSTR_W-1:0] word_align(input logic [INSTR_W-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of fetched {pc, instr} entries; head visible combinationally, zero-latency pop.
// Flush wins over a same-cycle push; the caller never pushes when full nor pops when empty.
module fetch_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, one outstanding imem req/ack, buffered valid/ready output; ack in N -> if_valid in N+1.
// Stops requesting when buffer plus outstanding fetch would overflow; redirect flushes and drains any stale fetch.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  pc_next;
    logic [CW-1:0] buf_count;
    logic [CW-1:0] count_next;
    logic         buf_empty;
    logic         buf_full;
    logic         push;
    logic         pop;
    logic         has_space;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign pop        = if_valid & if_ready;
    assign push       = imem_req & imem_ack & (state == FETCH) & ~redirect & ~buf_full;
    assign count_next = buf_count + CW'(push) - CW'(pop);
    assign has_space  = (count_next < CW'(BUF_DEPTH));
    assign pc_next    = redirect ? word_align(redirect_pc) : (push ? pc + 32'd4 : pc);

    assign push_entry.pc    = pc;
    assign push_entry.instr = imem_rdata;

    fetch_buffer #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_entry),
        .pop      (pop),
        .flush    (redirect),
        .head_dat (head),
        .count    (buf_count),
        .empty    (buf_empty),
        .full     (buf_full)
    );

    // imem_addr only diverges from pc while a pre-redirect fetch is being drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            pc <= pc_next;
            if (redirect) begin
                imem_req <= 1'b1;
                if (imem_req && !imem_ack) begin
                    state <= DRAIN;
                end else begin
                    state     <= FETCH;
                    imem_addr <= pc_next;
                end
            end else begin
                case (state)
                    DRAIN: begin
                        if (imem_ack) begin
                            state     <= FETCH;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end
                    end
                    default: begin
                        imem_addr <= pc_next;
                        if (has_space) begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            state    <= HOLD;
                            imem_req <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign if_valid    = ~buf_empty;
    assign if_instr    = if_valid ? head.instr : '0;
    assign if_pc       = if_valid ? head.pc : '0;
    assign if_pc_plus4 = if_valid ? head.pc + 32'd4 : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized and directed checks of instr_fetch_unit against a queue-based reference of the fetch stream.
module tb_instr_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] KEY   = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus4 (if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: words the stage must deliver, in order, plus the drain bookkeeping.
    logic [63:0] q[$];
    logic [31:0] exp_pc;
    logic [31:0] drain_addr;
    bit          draining;
    int          rem;
    int          lat_cfg;

    logic        s_req, s_ack, s_valid;
    logic [31:0] s_addr, s_pc, s_instr, s_p4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event not seen within cycle budget at %0t", name, $time);
    endtask

    function automatic int next_lat();
        return (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        if_ready    = 1'b0;
        q.delete();
        draining = 1'b0;
        exp_pc   = 32'h0;
        rem      = next_lat();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive inputs at negedge, sample and compare, then advance the reference.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc);
        bit          exp_req;
        bit          fire;
        bit          pop;
        logic [63:0] h;
        @(negedge clk);
        if_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (imem_req) begin
            if (rem == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = imem_addr ^ KEY;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                rem--;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
        end
        #1;
        s_req = imem_req;  s_addr = imem_addr; s_ack = imem_ack;
        s_valid = if_valid; s_pc = if_pc; s_instr = if_instr; s_p4 = if_pc_plus4;

        exp_req = draining || (q.size() < DEPTH);
        chk("if_valid", 32'(s_valid), 32'(q.size() > 0));
        chk("imem_req", 32'(s_req), 32'(exp_req));
        if (s_req && exp_req)
            chk("imem_addr", s_addr, draining ? drain_addr : exp_pc);
        if (s_valid && q.size() > 0) begin
            h = q[0];
            chk("if_pc", s_pc, h[63:32]);
            chk("if_instr", s_instr, h[31:0]);
            chk("if_pc_plus4", s_p4, h[63:32] + 32'd4);
        end

        fire = s_req && s_ack;
        pop  = s_valid && rdy;
        if (redir) begin
            q.delete();
            if (s_req && !s_ack) begin
                if (!draining)
                    drain_addr = exp_pc;
                draining = 1'b1;
            end else begin
                draining = 1'b0;
            end
            exp_pc = rpc & ~32'h3;
        end else begin
            if (pop && q.size() > 0)
                void'(q.pop_front());
            if (fire) begin
                if (draining) begin
                    draining = 1'b0;
                end else begin
                    q.push_back({exp_pc, exp_pc ^ KEY});
                    exp_pc = exp_pc + 32'd4;
                end
            end
        end
        if (fire)
            rem = next_lat();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        logic [31:0] rpc;

        // Zero-wait memory, ready=1: one instruction per cycle from 0.
        lat_cfg = 0;
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(imem_req), 32'h0);
        chk("rst_valid", 32'(if_valid), 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_plus4", if_pc_plus4, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0);
        chk("t1_c1_valid", 32'(s_valid), 32'h0);
        chk("t1_c1_req", 32'(s_req), 32'h1);
        step(1, 0, 0);
        chk("t1_first_valid", 32'(s_valid), 32'h1);
        chk("t1_pc0", s_pc, 32'h0);
        chk("t1_instr0", s_instr, 32'hA5A5_0000);
        step(1, 0, 0);
        chk("t1_pc4", s_pc, 32'h4);
        chk("t1_plus4", s_p4, 32'h8);
        step(1, 0, 0);
        chk("t1_pc8", s_pc, 32'h8);
        chk("t1_instr8", s_instr, 32'hA5A5_0008);
        repeat (6) step(1, 0, 0);

        // Stalled downstream: buffer fills with 0 and 4, requests stop, head holds.
        lat_cfg = 0;
        do_reset();
        step(0, 0, 0);
        step(0, 0, 0);
        chk("t2_valid", 32'(s_valid), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            chk("t2_hold_req", 32'(s_req), 32'h0);
            chk("t2_stable_pc", s_pc, 32'h0);
        end
        step(1, 0, 0);
        step(1, 0, 0);
        chk("t2_resume_req", 32'(s_req), 32'h1);
        chk("t2_resume_addr", s_addr, 32'h8);
        chk("t2_order_pc", s_pc, 32'h4);
        step(1, 0, 0);
        chk("t2_next_pc", s_pc, 32'h8);

        // Slow memory, redirect while the fetch at 0x8 is outstanding.
        lat_cfg = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1, 0, 0);
            if (s_req && s_addr == 32'h8)
                found = 1'b1;
        end
        if (!found) timeout("t3_req8");
        step(1, 1, 32'h100);
        chk("t3_redir_addr", s_addr, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(1, 0, 0);
            chk("t3_drain_addr", s_addr, 32'h8);
            if (s_ack)
                found = 1'b1;
        end
        if (!found) timeout("t3_drain_ack");
        step(1, 0, 0);
        chk("t3_new_req", 32'(s_req), 32'h1);
        chk("t3_new_addr", s_addr, 32'h100);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1, 0, 0);
            if (s_valid) begin
                found = 1'b1;
                chk("t3_first_pc", s_pc, 32'h100);
            end
        end
        if (!found) timeout("t3_valid");

        // Redirect (unaligned) coincident with the ack of 0x4 while 0x0 is buffered.
        lat_cfg = 0;
        do_reset();
        step(0, 0, 0);
        step(0, 1, 32'h203);
        chk("t4_ack_addr", s_addr, 32'h4);
        chk("t4_ack", 32'(s_ack), 32'h1);
        chk("t4_head", s_pc, 32'h0);
        step(1, 0, 0);
        chk("t4_flushed", 32'(s_valid), 32'h0);
        chk("t4_addr", s_addr, 32'h200);
        step(1, 0, 0);
        chk("t4_pc", s_pc, 32'h200);
        chk("t4_instr", s_instr, 32'hA5A5_0200);
        repeat (4) step(1, 0, 0);

        // Wrap at the top of the address space.
        lat_cfg = 0;
        do_reset();
        repeat (3) step(1, 0, 0);
        step(1, 1, 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1, 0, 0);
            if (s_valid) begin
                found = 1'b1;
                chk("t5_pc", s_pc, 32'hFFFF_FFFC);
                chk("t5_plus4", s_p4, 32'h0);
            end
        end
        if (!found) timeout("t5_valid");
        step(1, 0, 0);
        chk("t5_wrap_pc", s_pc, 32'h0);
        chk("t5_wrap_plus4", s_p4, 32'h4);

        // Asynchronous reset in the middle of an outstanding request.
        lat_cfg = 3;
        do_reset();
        repeat (6) step(0, 0, 0);
        chk("t6_pre_req", 32'(s_req), 32'h1);
        chk("t6_pre_valid", 32'(s_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_req_now", 32'(imem_req), 32'h0);
        chk("t6_valid_now", 32'(if_valid), 32'h0);
        lat_cfg = 0;
        do_reset();
        step(1, 0, 0);
        chk("t6_restart_req", 32'(imem_req), 32'h1);
        chk("t6_restart_addr", s_addr, 32'h0);
        repeat (4) step(1, 0, 0);

        // Random latency, backpressure and redirects.
        lat_cfg = -1;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0)
                rpc[31:5] = '1;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
